// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: exe commands, instruction modes, ARM condition codes
// and the control bundle layout.
package id_pkg;

  typedef enum logic [3:0] {
    ExeNop = 4'b0000,
    ExeMov = 4'b0001,
    ExeAdd = 4'b0010,
    ExeAdc = 4'b0011,
    ExeSub = 4'b0100,
    ExeSbc = 4'b0101,
    ExeAnd = 4'b0110,
    ExeOrr = 4'b0111,
    ExeEor = 4'b1000,
    ExeMvn = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    ModeDp    = 2'b00,
    ModeMem   = 2'b01,
    ModeBr    = 2'b10,
    ModeUndef = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  // ARM data-processing opcodes (instr[24:21])
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  typedef struct packed {
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     b;
    logic     s;
    exe_cmd_e exe_cmd;
  } ctrl_t;

  // sr is {N, Z, C, V}; 1111 is treated as unconditional
  function automatic logic cond_pass(input cond_e cond, input logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond)
      CondEq:  return z;
      CondNe:  return ~z;
      CondCs:  return c;
      CondCc:  return ~c;
      CondMi:  return n;
      CondPl:  return ~n;
      CondVs:  return v;
      CondVc:  return ~v;
      CondHi:  return c & ~z;
      CondLs:  return ~c | z;
      CondGe:  return n == v;
      CondLt:  return n != v;
      CondGt:  return ~z & (n == v);
      CondLe:  return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG x DW register file, two combinational read ports, one synchronous write port.
// WB_BYPASS_EN: a same-cycle write is forwarded to the read ports.
module id_regfile #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 16,
  localparam int unsigned RAW = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_i,
  input  logic [RAW-1:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [RAW-1:0] raddr1_i,
  input  logic [RAW-1:0] raddr2_i,
  output logic [DW-1:0]  rdata1_o,
  output logic [DW-1:0]  rdata2_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef WB_BYPASS_EN
  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];
`else
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
`endif

endmodule

// File: rtl/id_stage_pipelined.sv
// Instruction decode stage with register file, condition check and ID/EXE valid/ready register.
// Optional macro WB_BYPASS_EN enables write-through on the register-file read ports.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 16,
  localparam int unsigned RAW = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    instr,
  input  logic [DW-1:0]  pc_in,
  input  logic           wb_we,
  input  logic [RAW-1:0] wb_dest,
  input  logic [DW-1:0]  wb_data,
  input  logic           hazard,
  input  logic           flush,
  input  logic [3:0]     sr,
  output logic [RAW-1:0] src1,
  output logic [RAW-1:0] src2,
  output logic           two_src,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8:0]     ctrl_o,
  output logic [DW-1:0]  val_rn_o,
  output logic [DW-1:0]  val_rm_o,
  output logic           imm_o,
  output logic [11:0]    shift_op_o,
  output logic [23:0]    simm24_o,
  output logic [RAW-1:0] dest_o,
  output logic [DW-1:0]  pc_o
);

  mode_e          mode;
  logic [3:0]     opcode;
  logic           imm_bit;
  logic           store;
  logic [RAW-1:0] rn, rd, rm;
  logic [DW-1:0]  rdata1, rdata2;
  ctrl_t          dec;
  ctrl_t          issue_ctrl;
  logic           dp_def;
  logic           load;
  logic           accept;

  logic           valid_q, valid_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic [DW-1:0]  val_rn_q, val_rn_d;
  logic [DW-1:0]  val_rm_q, val_rm_d;
  logic           imm_q, imm_d;
  logic [11:0]    shift_op_q, shift_op_d;
  logic [23:0]    simm24_q, simm24_d;
  logic [RAW-1:0] dest_q, dest_d;
  logic [DW-1:0]  pc_q, pc_d;
  logic [RAW-1:0] src1_q, src1_d;
  logic [RAW-1:0] src2_q, src2_d;

  assign mode    = mode_e'(instr[27:26]);
  assign opcode  = instr[24:21];
  assign imm_bit = instr[25];
  assign store   = (mode == ModeMem) && !instr[20];
  assign rn      = RAW'(instr[19:16]);
  assign rd      = RAW'(instr[15:12]);
  assign rm      = RAW'(instr[3:0]);

  assign src1    = rn;
  assign src2    = store ? rd : rm;
  assign two_src = ~imm_bit | store;

  id_regfile #(
    .DW  (DW),
    .NREG(NREG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wb_we),
    .waddr_i (wb_dest),
    .wdata_i (wb_data),
    .raddr1_i(src1),
    .raddr2_i(src2),
    .rdata1_o(rdata1),
    .rdata2_o(rdata2)
  );

  always_comb begin
    dec    = '0;
    dp_def = 1'b1;
    case (mode)
      ModeDp: begin
        dec.wb_en = 1'b1;
        case (opcode)
          OpMov: dec.exe_cmd = ExeMov;
          OpMvn: dec.exe_cmd = ExeMvn;
          OpAdd: dec.exe_cmd = ExeAdd;
          OpAdc: dec.exe_cmd = ExeAdc;
          OpSub: dec.exe_cmd = ExeSub;
          OpSbc: dec.exe_cmd = ExeSbc;
          OpAnd: dec.exe_cmd = ExeAnd;
          OpOrr: dec.exe_cmd = ExeOrr;
          OpEor: dec.exe_cmd = ExeEor;
          OpCmp: begin
            dec.exe_cmd = ExeSub;
            dec.wb_en   = 1'b0;
          end
          OpTst: begin
            dec.exe_cmd = ExeAnd;
            dec.wb_en   = 1'b0;
          end
          default: dp_def = 1'b0;
        endcase
        dec.s = instr[20];
        if (!dp_def) begin
          dec = '0;
        end
      end
      ModeMem: begin
        dec.exe_cmd  = ExeAdd;
        dec.mem_r_en = instr[20];
        dec.wb_en    = instr[20];
        dec.mem_w_en = ~instr[20];
      end
      ModeBr:  dec.b = 1'b1;
      default: dec = '0;
    endcase
  end

  assign issue_ctrl = cond_pass(cond_e'(instr[31:28]), sr) ? dec : '0;

  assign load     = ~valid_q | out_ready;
  assign in_ready = flush | (load & ~hazard);
  assign accept   = load & in_valid & ~hazard & ~flush;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    val_rn_d   = val_rn_q;
    val_rm_d   = val_rm_q;
    imm_d      = imm_q;
    shift_op_d = shift_op_q;
    simm24_d   = simm24_q;
    dest_d     = dest_q;
    pc_d       = pc_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    if (flush || (load && !accept)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (accept) begin
      valid_d    = 1'b1;
      ctrl_d     = issue_ctrl;
      val_rn_d   = rdata1;
      val_rm_d   = rdata2;
      imm_d      = imm_bit;
      shift_op_d = instr[11:0];
      simm24_d   = instr[23:0];
      dest_d     = rd;
      pc_d       = pc_in;
      src1_d     = src1;
      src2_d     = src2;
    end else begin
      // Holding: keep operands coherent with write-backs that land while EXE is stalled
      if (wb_we && (wb_dest == src1_q)) val_rn_d = wb_data;
      if (wb_we && (wb_dest == src2_q)) val_rm_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      val_rn_q   <= '0;
      val_rm_q   <= '0;
      imm_q      <= 1'b0;
      shift_op_q <= '0;
      simm24_q   <= '0;
      dest_q     <= '0;
      pc_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      val_rn_q   <= val_rn_d;
      val_rm_q   <= val_rm_d;
      imm_q      <= imm_d;
      shift_op_q <= shift_op_d;
      simm24_q   <= simm24_d;
      dest_q     <= dest_d;
      pc_q       <= pc_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
    end
  end

  assign out_valid  = valid_q;
  assign ctrl_o     = ctrl_q;
  assign val_rn_o   = val_rn_q;
  assign val_rm_o   = val_rm_q;
  assign imm_o      = imm_q;
  assign shift_op_o = shift_op_q;
  assign simm24_o   = simm24_q;
  assign dest_o     = dest_q;
  assign pc_o       = pc_q;

endmodule

// File: doc/id_stage_pipelined.md
ID_STAGE_PIPELINED -- requirements
Module: id_stage_pipelined

Interface
REQ-001 Parameter DW, default 32, register-file and operand data width.
REQ-002 Parameter NREG, default 16, register count; RAW = $clog2(NREG); instruction register fields are 4 bits, zero-extended or truncated to RAW.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  instr/pc_in valid from IF register.
REQ-006 in_ready  out  1  stage accepts instr this cycle.
REQ-007 instr  in  32  instruction word.
REQ-008 pc_in  in  DW  PC of instr.
REQ-009 wb_we  in  1  write-back enable.
REQ-010 wb_dest  in  RAW  write-back register index.
REQ-011 wb_data  in  DW  write-back value.
REQ-012 hazard  in  1  RAW hazard from hazard unit; insert bubble.
REQ-013 flush  in  1  taken branch; kill current and incoming instruction.
REQ-014 sr  in  4  status flags {N,Z,C,V}.
REQ-015 src1 / src2 / two_src  out  RAW/RAW/1  combinational to hazard unit: src1=Rn, src2=Rd if store else Rm, two_src=~I | store.
REQ-016 out_valid  out  1  ID/EXE register holds an instruction.
REQ-017 out_ready  in  1  EXE consumes the ID/EXE register this cycle.
REQ-018 ctrl_o  out  9  {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd[3:0]}.
REQ-019 val_rn_o / val_rm_o  out  DW  operand values.
REQ-020 imm_o, shift_op_o, simm24_o, dest_o, pc_o  out  1/12/24/RAW/DW  instr[25], instr[11:0], instr[23:0], Rd, pc_in.

Function
REQ-021 Register file: NREG x DW, write on rising edge when wb_we, two combinational read ports addressed by src1/src2.
REQ-022 Decode: mode 00 data processing per opcode: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000; wb_en=1 except CMP/TST; s=instr[20].
REQ-023 Decode: mode 01 LDR (instr[20]=1: mem_r_en, wb_en) / STR (mem_w_en), exe_cmd 0010; mode 10 branch: b=1, all else 0; undefined encodings yield ctrl 0.
REQ-024 Condition check per ARM cond field (EQ..AL, 16 codes) against sr; failed condition forces ctrl_o=0 with out_valid=1.
REQ-025 load = ~out_valid | out_ready; in_ready = load & ~hazard, or 1 when flush.
REQ-026 load & in_valid & ~hazard & ~flush: register all outputs next edge, out_valid=1; latency one cycle.
REQ-027 load & (hazard | ~in_valid) & ~flush: out_valid=0, ctrl_o=0 next edge (bubble); instr not consumed under hazard.
REQ-028 flush has highest priority: next edge out_valid=0, ctrl_o=0, incoming instr dropped, regardless of out_ready/hazard.
REQ-029 Hold (out_valid & ~out_ready & ~flush): all outputs stable, except val_rn_o/val_rm_o refreshed with wb_data when wb_we and wb_dest equals the held source index.
REQ-030 Simultaneous wb write and load: operand capture per REQ-041/042.

Reset
REQ-031 rst high at an edge: out_valid=0, ctrl_o=0, all data outputs 0, all registers 0; overrides flush, hazard and wb_we.
REQ-032 Reset mid-hold discards the held instruction; in_ready=1 the cycle after rst deasserts (given no hazard).

Configuration
REQ-041 Macro WB_BYPASS_EN defined: read ports return wb_data when wb_we & wb_dest==src in the same cycle (write-through).
REQ-042 WB_BYPASS_EN undefined: read ports return array contents only; same-cycle write visible next cycle; hazard unit covers the gap.

Structure
REQ-051 Package id_pkg holds exe_cmd constants, mode and cond encodings, and the ctrl_o field layout.
REQ-052 One sub-module, id_regfile (NREG x DW, bypass under WB_BYPASS_EN); decode, condition check and stage register stay in id_stage_pipelined.

Verification
REQ-061 ADD R1,R2,R3 (AL), R2=5,R3=7, out_ready=1 -> next cycle out_valid=1, exe_cmd=0010, wb_en=1, val_rn_o=5, val_rm_o=7.
REQ-062 ADDEQ with sr Z=0 -> out_valid=1, ctrl_o=0; with Z=1 -> wb_en=1.
REQ-063 hazard=1 for 2 cycles on a valid SUB -> in_ready=0, two bubbles, then SUB issued with exe_cmd=0100.
REQ-064 out_ready=0 holding val_rn_o=5 from R2; wb writes R2=9 -> val_rn_o=9 next cycle, other outputs unchanged.
REQ-065 flush with valid instr and out_ready=0 -> next cycle out_valid=0, ctrl_o=0, instr dropped.
REQ-066 wb_we R4=0x55 in the same cycle STR reads R4 -> val_rm_o=0x55 with WB_BYPASS_EN, old value without.
